// File: rtl/egg_timer.sv
// Count-up egg timer: a start edge arms a run that ticks every TICK_DIV cycles
// up to a captured terminal count, then blinks the LEDs until restarted.
module egg_timer #(
  parameter int SIZE      = 4,
  parameter int TICK_DIV  = 64,
  parameter int BLINK_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] max,
  output logic [SIZE-1:0] led
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  state_t          state, state_nx;
  logic [SIZE-1:0] count, count_nx;
  logic [SIZE-1:0] max_q, max_q_nx;
  logic [SIZE-1:0] led_nx;
  logic [TW-1:0]   presc, presc_nx;
  logic [BW-1:0]   blink_cnt, blink_nx;
  logic            phase, phase_nx;
  logic            start_q;
  logic            start_pulse;
  logic            tick;
  logic            enable;
  logic            alarm;

  assign start_pulse = start & ~start_q;
  assign enable      = (state == RUN);
  assign alarm       = (state == ALARM);
  assign tick        = enable && (presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      max_q     <= '0;
      presc     <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      led       <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      max_q     <= max_q_nx;
      presc     <= presc_nx;
      blink_cnt <= blink_nx;
      phase     <= phase_nx;
      led       <= led_nx;
      start_q   <= start;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    max_q_nx = max_q;
    presc_nx = presc;
    blink_nx = blink_cnt;
    phase_nx = phase;
    led_nx   = '0;

    case (state)
      RUN: begin
        led_nx = count;
        // Terminal check runs every cycle, so max_q == 0 alarms right away
        if (count == max_q) begin
          state_nx = ALARM;
          presc_nx = '0;
          blink_nx = '0;
          phase_nx = 1'b1;
        end else if (tick) begin
          presc_nx = '0;
          count_nx = count + SIZE'(1);
        end else begin
          presc_nx = presc + TW'(1);
        end
      end
      ALARM: begin
        led_nx = {SIZE{phase}};
        if (blink_cnt == BLINK_LAST) begin
          blink_nx = '0;
          phase_nx = ~phase;
        end else begin
          blink_nx = blink_cnt + BW'(1);
        end
      end
      IDLE:    led_nx = '0;
      default: state_nx = IDLE;
    endcase

    // A restart beats any tick or blink activity in the same cycle
    if (start_pulse) begin
      state_nx = RUN;
      count_nx = '0;
      presc_nx = '0;
      blink_nx = '0;
      phase_nx = 1'b0;
      max_q_nx = max;
    end
  end

endmodule

// File: tb/tb_egg_timer.sv
// Bench for egg_timer: directed vector table, blink sequence and random
// stimulus, all checked every cycle against an elapsed-time reference model.
module tb_egg_timer;

  localparam int SIZE = 4;
  localparam int TD   = 64;
  localparam int BD   = 16;
  localparam int ONES = (1 << SIZE) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] max;
  logic [SIZE-1:0] led;

  egg_timer #(.SIZE(SIZE), .TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .max  (max),
    .led  (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: whether a run was ever started, cycles since the start edge,
  // captured terminal count, previous start level and expected led.
  bit mStarted   = 1'b0;
  int mN         = 0;
  int mMax       = 0;
  bit mPrevStart = 1'b0;
  int mLed       = 0;

  function automatic int mCount();
    if (!mStarted) return 0;
    return ((mN / TD) < mMax) ? (mN / TD) : mMax;
  endfunction

  function automatic bit mEnable();
    return mStarted && (mN <= TD * mMax);
  endfunction

  function automatic bit mAlarm();
    return mStarted && (mN > TD * mMax);
  endfunction

  function automatic int mLedSrc();
    if (mEnable()) return mCount();
    if (mAlarm())  return ((((mN - (TD * mMax + 1)) / BD) % 2) == 0) ? ONES : 0;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit r, input bit s, input int m);
    rst   = r;
    start = s;
    max   = SIZE'(m);
    @(posedge clk);
    if (r) begin
      mStarted   = 1'b0;
      mN         = 0;
      mMax       = 0;
      mPrevStart = 1'b0;
      mLed       = 0;
    end else begin
      mLed = mLedSrc();
      if (s && !mPrevStart) begin
        mStarted = 1'b1;
        mN       = 0;
        mMax     = m % (1 << SIZE);
      end else if (mStarted) begin
        mN++;
      end
      mPrevStart = s;
    end
    #1;
    checkOutput("model.enable", int'(dut.enable), int'(mEnable()));
    checkOutput("model.alarm",  int'(dut.alarm),  int'(mAlarm()));
    checkOutput("model.count",  int'(dut.count),  mCount());
    checkOutput("model.led",    int'(led),        mLed);
  endtask

  typedef struct {
    bit rst;
    bit start;
    int max;
    int cycles;
    bit en;
    bit al;
    int cnt;
    int led;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int expBlink;
    int budget;
    bit s;
    int m;

    vecs.push_back(vec_t'{1, 0,  0,    3, 0, 0,  0,  0});
    vecs.push_back(vec_t'{0, 0,  0,  100, 0, 0,  0,  0});
    vecs.push_back(vec_t'{0, 1,  7,    3, 1, 0,  0,  0});
    vecs.push_back(vec_t'{0, 0,  7,   63, 1, 0,  1,  1});
    vecs.push_back(vec_t'{0, 0,  7,  383, 1, 0,  7,  6});
    vecs.push_back(vec_t'{0, 0,  7,    1, 0, 1,  7,  7});
    vecs.push_back(vec_t'{0, 0,  7,    1, 0, 1,  7, 15});
    vecs.push_back(vec_t'{0, 0,  7,   16, 0, 1,  7,  0});
    vecs.push_back(vec_t'{0, 0,  7, 5000, 0, 1,  7,  0});
    vecs.push_back(vec_t'{0, 1,  3,    1, 1, 0,  0,  0});
    vecs.push_back(vec_t'{0, 1,  9,  200, 0, 1,  3, 15});
    vecs.push_back(vec_t'{0, 0,  0,    1, 0, 1,  3, 15});
    vecs.push_back(vec_t'{0, 1,  0,    1, 1, 0,  0, 15});
    vecs.push_back(vec_t'{0, 0,  0,    1, 0, 1,  0,  0});
    vecs.push_back(vec_t'{0, 0,  0,    1, 0, 1,  0, 15});
    vecs.push_back(vec_t'{0, 1, 15,    1, 1, 0,  0, 15});
    vecs.push_back(vec_t'{0, 0,  0,  960, 1, 0, 15, 14});
    vecs.push_back(vec_t'{0, 0,  0,    1, 0, 1, 15, 15});
    vecs.push_back(vec_t'{0, 1, 10,    1, 1, 0,  0, 15});
    vecs.push_back(vec_t'{0, 0, 10,  200, 1, 0,  3,  3});
    vecs.push_back(vec_t'{0, 1, 10,    1, 1, 0,  0,  3});
    vecs.push_back(vec_t'{0, 0, 10,   63, 1, 0,  0,  0});
    vecs.push_back(vec_t'{0, 0, 10,    1, 1, 0,  1,  0});
    vecs.push_back(vec_t'{1, 0, 10,    1, 0, 0,  0,  0});
    vecs.push_back(vec_t'{1, 1,  5,    2, 0, 0,  0,  0});
    vecs.push_back(vec_t'{0, 1,  2,    1, 1, 0,  0,  0});
    vecs.push_back(vec_t'{0, 0,  2,  200, 0, 1,  2, 15});
    vecs.push_back(vec_t'{1, 0,  2,    1, 0, 0,  0,  0});

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].cycles) applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].max);
      checkOutput($sformatf("vec%0d.enable", i), int'(dut.enable), int'(vecs[i].en));
      checkOutput($sformatf("vec%0d.alarm",  i), int'(dut.alarm),  int'(vecs[i].al));
      checkOutput($sformatf("vec%0d.count",  i), int'(dut.count),  vecs[i].cnt);
      checkOutput($sformatf("vec%0d.led",    i), int'(led),        vecs[i].led);
    end

    $display("[TB] blink sequence");
    applyStimulus(1'b0, 1'b1, 1);
    budget = 300;
    while (!dut.alarm && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 1);
      budget--;
    end
    if (budget == 0) checkOutput("alarmTimeout", int'(dut.alarm), 1);
    applyStimulus(1'b0, 1'b0, 1);
    expBlink = ONES;
    checkOutput("blink.first", int'(led), expBlink);
    for (int k = 0; k < 6; k++) begin
      repeat (BD) applyStimulus(1'b0, 1'b0, 1);
      expBlink = (expBlink == ONES) ? 0 : ONES;
      checkOutput($sformatf("blink%0d", k), int'(led), expBlink);
    end

    $display("[TB] random stimulus");
    s = 1'b0;
    m = 0;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(299) == 0) s = ~s;
      if ($urandom_range(19) == 0)  m = int'($urandom_range(15));
      applyStimulus($urandom_range(999) == 0, s, m);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/egg_timer.md
Name: egg_timer

Overview:
- Count-up "egg timer": a `start` pulse arms a run.
- While running, a free-running prescaler produces periodic ticks. Each tick advances a SIZE-bit count until it equals the programmed `max`.
- At `max` the timer raises an alarm and blinks the LEDs until restarted or reset.
- Top-level user block: drives LEDs directly from button/switch inputs that are already synchronised to `clk`.

Parameters:
- SIZE, 4, width of `max`, `led` and the internal `count`.
- TICK_DIV, 64, clock cycles per count tick (≥2).
- BLINK_DIV, 16, clock cycles per LED blink half-period in alarm (≥2).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  start/restart request, level; only the rising edge acts.
- max  input  SIZE  terminal count, unsigned; captured at start.
- led  output  SIZE  display: count while running, blink pattern in alarm.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Internal signals must keep these exact names for hierarchical probing by benches:
  - `enable` (1 = run in progress)
  - `alarm` (1 = alarm active)
  - `count` (SIZE bits)
- Reset (`rst`=1 at a clock edge) overrides everything. It clears: state to IDLE, `enable`=0, `alarm`=0, `count`=0, prescaler=0, blink counter=0, blink phase=0, `led`=0, start-edge register=0, captured max=0.
- Start detection: register `start` each cycle. start_pulse = `start` & ~start_q. A level held for many cycles produces one pulse.
- States: IDLE, RUN, ALARM. `enable` = (state==RUN); `alarm` = (state==ALARM).
- start_pulse in any state, including RUN and ALARM, takes effect the next edge:
  - state→RUN, `count`=0, prescaler=0, blink counter/phase=0;
  - max_q ← `max`.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - A tick occurs on the cycle the prescaler equals TICK_DIV-1.
  - On a tick with `count` != max_q: `count` ← `count`+1.
  - Whenever `count` == max_q (evaluated every RUN cycle): next edge state→ALARM. `count` holds at max_q; prescaler stops and clears.
  - Consequence: max_q=0 gives ALARM one cycle after entering RUN.
  - Changes to `max` during RUN/ALARM are ignored.
- ALARM:
  - The blink counter counts 0..BLINK_DIV-1; blink phase toggles on each wrap.
  - The first half-period has phase=1.
  - `count` holds.
  - Exit only via start_pulse (restart) or `rst`.
- IDLE: `count` holds (0 after reset); no ticks.
- `led` is registered, one cycle behind state:
  - IDLE: 0.
  - RUN: `count`.
  - ALARM: all ones when phase=1, all zeros when phase=0.
- Arithmetic: unsigned SIZE-bit. `count` never exceeds max_q, so no wrap-around. Full-scale max (2^SIZE-1) must work without overflow.
- Simultaneous start_pulse and tick: restart wins. Simultaneous `rst` and start: reset wins.

Test Plan:
- Reset: hold `rst` 3 cycles with `start`=0 → `enable`=0, `alarm`=0, `count`=0, `led`=0. Values persist for 100 idle cycles.
- Nominal run, SIZE=4, TICK_DIV=64, max=7, `start` high 3 cycles → `enable`=1 for one run.
  - `count` increments every 64 cycles.
  - `alarm`=1 about 7×64 cycles after start; `count`=7, `enable`=0.
  - Alarm persists more than 5000 cycles with `led` toggling 1111/0000 every 16 cycles.
- max=0 → ALARM one cycle after RUN entry; `count` stays 0.
- max=15 → `count` reaches 15 after 15 ticks, then alarm. No wrap to 0.
- Restart: start_pulse mid-run at `count`=3 → `count`=0 and a fresh 64-cycle tick period. Start during ALARM → `alarm`=0, `enable`=1, `count`=0.
- Mid-run behaviour:
  - Changing `max` during RUN has no effect on the terminal count.
  - `rst` asserted during RUN or ALARM returns all signals to reset values on the next edge.
